stage_fetch: RTL

Instruction-fetch pipeline stage and producer of `stage_if`. The decode stage latches `stage_if` on every non-stalled cycle.
- Holds the PC and issues requests to the instruction cache over a ready-based handshake.
- Buffers one returned instruction while the pipeline is stalled.
- Handles branch redirects, including redirects that arrive while a cache miss is outstanding.

---
 rtl/stage_pkg.sv | 26 ++
 rtl/stage_fetch.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/stage_pkg.sv
// Shared pipeline-stage record, the bubble constructor and the optional trace printer.
// stage_print is compiled only when STAGE_FETCH_TRACE_EN is defined.
package stage_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] result;
    } t_stage;

    function automatic t_stage stage_flush();
        t_stage s;
        s = '0;
        return s;
    endfunction

`ifdef STAGE_FETCH_TRACE_EN
    function automatic void stage_print(input string tag, input t_stage s);
        $display("%s: pc=%08h instr=%08h rd=%0d we=%0b res=%08h",
                 tag, s.pc, s.instruction, s.rd, s.rd_we, s.result);
    endfunction
`endif

endpackage

// File: rtl/stage_fetch.sv
// Instruction fetch: PC, ready-handshake icache requests (1/cycle on hits), one-entry stall buffer, redirects incl. mid-miss.
// Latency: a completed fetch reaches stage_if on the completion edge; a stalled completion parks in the buffer and is released on unstall.
// Backpressure: stall freezes stage_if; no request is issued while the buffer is full. Trace printing: define STAGE_FETCH_TRACE_EN.
module stage_fetch
    import stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output t_stage      stage_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } t_state;

    t_state      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic        imem_req_nxt;
    logic [31:0] imem_addr_nxt;
    t_stage      stage_if_nxt;
    t_stage      buf_q, buf_nxt;
    t_stage      fetched;
    logic        done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            pend_pc   <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            stage_if  <= stage_flush();
            buf_q     <= stage_flush();
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            pend_pc   <= pend_pc_nxt;
            imem_req  <= imem_req_nxt;
            imem_addr <= imem_addr_nxt;
            stage_if  <= stage_if_nxt;
            buf_q     <= buf_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        pend_pc_nxt   = pend_pc;
        imem_req_nxt  = imem_req;
        imem_addr_nxt = imem_addr;
        stage_if_nxt  = stage_if;
        buf_nxt       = buf_q;
        done          = imem_req && imem_ready;

        fetched             = stage_flush();
        fetched.pc          = imem_addr;
        fetched.instruction = imem_data;

        case (state)
            S_IDLE: begin
                imem_req_nxt = 1'b1;
                state_nxt    = S_REQ;
                if (redirect) begin
                    pc_nxt        = redirect_pc;
                    imem_addr_nxt = redirect_pc;
                end else begin
                    imem_addr_nxt = pc;
                end
                if (!stall) stage_if_nxt = stage_flush();
            end

            S_REQ: begin
                if (redirect) begin
                    if (done) begin
                        pc_nxt        = redirect_pc;
                        imem_addr_nxt = redirect_pc;
                    end else begin
                        // The miss must still complete on the old address; its data is thrown away in DROP.
                        pend_pc_nxt = redirect_pc;
                        state_nxt   = S_DROP;
                    end
                    if (!stall) stage_if_nxt = stage_flush();
                end else if (done) begin
                    pc_nxt = pc + PC_STEP;
                    if (stall) begin
                        buf_nxt      = fetched;
                        imem_req_nxt = 1'b0;
                        state_nxt    = S_HOLD;
                    end else begin
                        stage_if_nxt  = fetched;
                        imem_addr_nxt = pc + PC_STEP;
                    end
                end else if (!stall) begin
                    stage_if_nxt = stage_flush();
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_nxt        = redirect_pc;
                    imem_addr_nxt = redirect_pc;
                    imem_req_nxt  = 1'b1;
                    buf_nxt       = stage_flush();
                    state_nxt     = S_REQ;
                    if (!stall) stage_if_nxt = stage_flush();
                end else if (!stall) begin
                    stage_if_nxt  = buf_q;
                    buf_nxt       = stage_flush();
                    imem_addr_nxt = pc;
                    imem_req_nxt  = 1'b1;
                    state_nxt     = S_REQ;
                end
            end

            S_DROP: begin
                if (redirect) pend_pc_nxt = redirect_pc;
                if (done) begin
                    pc_nxt        = redirect ? redirect_pc : pend_pc;
                    imem_addr_nxt = redirect ? redirect_pc : pend_pc;
                    state_nxt     = S_REQ;
                end
                if (!stall) stage_if_nxt = stage_flush();
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef STAGE_FETCH_TRACE_EN
    always @(negedge clock) begin
        if (!reset) begin
            stage_print("IF", stage_if);
            if (redirect) $display("IF redirect: pc %08h -> %08h", pc, redirect_pc);
        end
    end
`endif

endmodule
